// File: rtl/srl_fifo_fwft_pkg.sv
// Shared sizing helpers for the SRL channel FIFOs: capacity and count-width derivation.
package fifo_cfg_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Output register adds one storage slot on top of the SRL entries.
  function automatic int cap_of(input int depth, input int out_reg);
    return depth + out_reg;
  endfunction

  function automatic int cnt_w_of(input int depth, input int out_reg);
    return clog2(cap_of(depth, out_reg) + 1);
  endfunction

endpackage

// File: rtl/srl_fifo_fwft_if.sv
// Producer/consumer handshake bundle for the SRL stream FIFO.
interface srl_fifo_fwft_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;

  modport slave (
    input  if_write, if_din, if_read,
    output if_full_n, if_dout, if_empty_n
  );

  modport master (
    output if_write, if_din, if_read,
    input  if_full_n, if_dout, if_empty_n
  );
endinterface

// File: rtl/srl_fifo_fwft_chk.sv
// Occupancy sanity checker bound alongside the FIFO.
module srl_fifo_fwft_chk #(
  parameter int CNT_W = 5,
  parameter int CAP   = 17
) (
  input logic             clk,
  input logic             reset,
  input logic [CNT_W-1:0] count
);
  a_count_le_cap: assert property (@(posedge clk) disable iff (reset) count <= CNT_W'(CAP));
endmodule

// File: rtl/srl_fifo_fwft_storage.sv
// Shift-register storage: newest word enters at index 0, combinational read at addr, no reset.
module srl_fifo_storage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Shift the whole array by one slot on every accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i-1];
      end
    end
  end

  assign dout = mem_r[addr];
endmodule

// File: rtl/srl_fifo_fwft.sv
// SRL-based stream FIFO with occupancy, registered full/empty, optional FWFT output register,
// almost thresholds, synchronous flush and sticky overflow/underflow flags.
module srl_fifo_fwft
  import fifo_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int OUT_REG    = 1,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  localparam int CAP       = cap_of(DEPTH, OUT_REG),
  localparam int CNT_W     = cnt_w_of(DEPTH, OUT_REG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  srl_fifo_fwft_if.slave       fifo,
  output logic [CNT_W-1:0]     count,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 err_ovf,
  output logic                 err_udf
);
  logic [CNT_W-1:0]      count_r, count_next_s, srl_cnt_r, srl_cnt_next_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_next_s;
  logic                  full_n_r, full_n_next_s, empty_n_r, empty_n_next_s;
  logic                  out_valid_r, out_valid_next_s;
  logic [DATA_WIDTH-1:0] dout_r, dout_next_s, srl_dout_s;
  logic                  wr_s, rd_s, load_s, srl_pop_s;
  logic                  ovf_r, udf_r;

  srl_fifo_storage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_storage (
    .clk (clk),
    .we  (wr_s),
    .addr(addr_r),
    .din (fifo.if_din),
    .dout(srl_dout_s)
  );

  // Handshake acceptance, SRL/output-stage movement and next-state flags.
  always_comb begin
    wr_s = fifo.if_write & full_n_r & ~flush;
    rd_s = fifo.if_read & empty_n_r & ~flush;
    if (OUT_REG != 0) begin
      load_s = (~out_valid_r | rd_s) & (srl_cnt_r != CNT_W'(0)) & ~flush;
    end else begin
      load_s = 1'b0;
    end
    // Without the output stage a consumer read pops the SRL directly.
    srl_pop_s = (OUT_REG != 0) ? load_s : rd_s;

    count_next_s     = count_r;
    srl_cnt_next_s   = srl_cnt_r;
    out_valid_next_s = out_valid_r;
    dout_next_s      = dout_r;
    if (flush) begin
      count_next_s     = CNT_W'(0);
      srl_cnt_next_s   = CNT_W'(0);
      out_valid_next_s = 1'b0;
      dout_next_s      = {DATA_WIDTH{1'b0}};
    end else begin
      case ({wr_s, rd_s})
        2'b10:   count_next_s = count_r + CNT_W'(1);
        2'b01:   count_next_s = count_r - CNT_W'(1);
        default: count_next_s = count_r;
      endcase
      case ({wr_s, srl_pop_s})
        2'b10:   srl_cnt_next_s = srl_cnt_r + CNT_W'(1);
        2'b01:   srl_cnt_next_s = srl_cnt_r - CNT_W'(1);
        default: srl_cnt_next_s = srl_cnt_r;
      endcase
      if (load_s) begin
        out_valid_next_s = 1'b1;
        dout_next_s      = srl_dout_s;
      end else if (rd_s) begin
        out_valid_next_s = 1'b0;
      end else begin
        out_valid_next_s = out_valid_r;
      end
    end

    // Oldest SRL word sits at occupancy-1; parked at 0 when the SRL is empty.
    addr_next_s    = (srl_cnt_next_s == CNT_W'(0)) ? ADDR_WIDTH'(0)
                                                   : ADDR_WIDTH'(srl_cnt_next_s - CNT_W'(1));
    empty_n_next_s = (OUT_REG != 0) ? out_valid_next_s : (srl_cnt_next_s != CNT_W'(0));
    full_n_next_s  = (count_next_s < CNT_W'(CAP));
  end

  // State, handshake flags and sticky error capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r     <= CNT_W'(0);
      srl_cnt_r   <= CNT_W'(0);
      addr_r      <= ADDR_WIDTH'(0);
      full_n_r    <= 1'b1;
      empty_n_r   <= 1'b0;
      out_valid_r <= 1'b0;
      dout_r      <= {DATA_WIDTH{1'b0}};
      ovf_r       <= 1'b0;
      udf_r       <= 1'b0;
    end else begin
      count_r     <= count_next_s;
      srl_cnt_r   <= srl_cnt_next_s;
      addr_r      <= addr_next_s;
      full_n_r    <= full_n_next_s;
      empty_n_r   <= empty_n_next_s;
      out_valid_r <= out_valid_next_s;
      dout_r      <= dout_next_s;
      ovf_r       <= ovf_r | (fifo.if_write & ~full_n_r);
      udf_r       <= udf_r | (fifo.if_read & ~empty_n_r);
    end
  end

  assign fifo.if_full_n  = full_n_r;
  assign fifo.if_empty_n = empty_n_r;
  assign fifo.if_dout    = (OUT_REG != 0) ? dout_r : srl_dout_s;
  assign count           = count_r;
  assign almost_full     = (count_r >= CNT_W'(AF_LEVEL));
  assign almost_empty    = (count_r <= CNT_W'(AE_LEVEL));
  assign err_ovf         = ovf_r;
  assign err_udf         = udf_r;

  srl_fifo_fwft_chk #(
    .CNT_W(CNT_W),
    .CAP  (CAP)
  ) u_chk (
    .clk  (clk),
    .reset(reset),
    .count(count_r)
  );
endmodule

// File: tb/tb_srl_fifo_fwft.sv
// Self-checking bench: vector table for fill/drain plus scoreboarded corner-case sequences.
module tb_srl_fifo_fwft;
  import fifo_cfg_pkg::*;

  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int CAP    = 17;
  localparam int AF     = 14;
  localparam int AE     = 2;
  localparam int CNT_W0 = cnt_w_of(DEPTH, 1);
  localparam int CNT_W1 = cnt_w_of(DEPTH, 0);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic flush1 = 1'b0;
  logic [CNT_W0-1:0] count0;
  logic [CNT_W1-1:0] count1;
  logic af0, ae0, ovf0, udf0, af1, ae1, ovf1, udf1;

  srl_fifo_fwft_if #(.DATA_WIDTH(DW)) f0 ();
  srl_fifo_fwft_if #(.DATA_WIDTH(DW)) f1 ();

  srl_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .DEPTH(DEPTH), .OUT_REG(1)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .fifo(f0), .count(count0),
    .almost_full(af0), .almost_empty(ae0), .err_ovf(ovf0), .err_udf(udf0));

  srl_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .DEPTH(DEPTH), .OUT_REG(0)) u1 (
    .clk(clk), .reset(reset), .flush(flush1), .fifo(f1), .count(count1),
    .almost_full(af1), .almost_empty(ae1), .err_ovf(ovf1), .err_udf(udf1));

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        rd;
    int          exp_count;
    logic        exp_full_n;
    logic        exp_empty_n;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];
  int          m_count = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input int exp_cnt, input logic exp_full_n,
                            input logic exp_empty_n);
    chk({tag, ".count"}, 64'(count0), 64'(exp_cnt));
    chk({tag, ".full_n"}, 64'(f0.if_full_n), 64'(exp_full_n));
    chk({tag, ".empty_n"}, 64'(f0.if_empty_n), 64'(exp_empty_n));
    chk({tag, ".almost_full"}, 64'(af0), 64'(exp_cnt >= AF));
    chk({tag, ".almost_empty"}, 64'(ae0), 64'(exp_cnt <= AE));
  endtask

  // One clock of stimulus on u0, starting and ending at a falling edge.
  task automatic cycle(input logic wr, input logic [31:0] din, input logic rd, input logic fl);
    logic        w_acc;
    logic [31:0] exp_d;
    f0.if_write = wr;
    f0.if_din   = din;
    f0.if_read  = rd;
    flush       = fl;
    #1;
    w_acc = wr && !fl && (m_count < CAP);
    if (rd && !fl && f0.if_empty_n) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_data: read accepted, got 0x%0h, expected no data", f0.if_dout);
      end else begin
        exp_d = sb.pop_front();
        chk("rd_data", 64'(f0.if_dout), 64'(exp_d));
      end
      m_count--;
    end
    if (fl) begin
      sb.delete();
      m_count = 0;
    end else if (w_acc) begin
      sb.push_back(din);
      m_count++;
    end
    @(posedge clk);
    @(negedge clk);
    f0.if_write = 1'b0;
    f0.if_read  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && m_count > 0; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk_status(tag, 0, 1'b1, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_count = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    f0.if_write = 1'b0; f0.if_read = 1'b0; f0.if_din = 32'h0;
    f1.if_write = 1'b0; f1.if_read = 1'b0; f1.if_din = 32'h0;

    // Vector table: fill to capacity, refused overflow write, drain, underflow read.
    for (int k = 1; k <= CAP; k++) begin
      tbl.push_back('{wr: 1'b1, din: 32'(k - 1), rd: 1'b0, exp_count: k,
                      exp_full_n: (k < CAP), exp_empty_n: (k >= 2)});
    end
    tbl.push_back('{wr: 1'b1, din: 32'h99, rd: 1'b0, exp_count: CAP,
                    exp_full_n: 1'b0, exp_empty_n: 1'b1});
    for (int j = 1; j <= CAP; j++) begin
      tbl.push_back('{wr: 1'b0, din: 32'h0, rd: 1'b1, exp_count: CAP - j,
                      exp_full_n: 1'b1, exp_empty_n: (j < CAP)});
    end
    tbl.push_back('{wr: 1'b0, din: 32'h0, rd: 1'b1, exp_count: 0,
                    exp_full_n: 1'b1, exp_empty_n: 1'b0});

    @(negedge clk);
    @(negedge clk);
    chk_status("reset", 0, 1'b1, 1'b0);
    chk("reset.err_ovf", 64'(ovf0), 64'h0);
    chk("reset.err_udf", 64'(udf0), 64'h0);
    chk("reset.dout", 64'(f0.if_dout), 64'h0);
    chk("reset1.count", 64'(count1), 64'h0);
    chk("reset1.full_n", 64'(f1.if_full_n), 64'h1);
    chk("reset1.empty_n", 64'(f1.if_empty_n), 64'h0);
    chk("reset1.flags", 64'({af1, ae1, ovf1, udf1}), 64'b0100);
    reset = 1'b0;

    foreach (tbl[i]) begin
      cycle(tbl[i].wr, tbl[i].din, tbl[i].rd, 1'b0);
      chk_status($sformatf("vec%0d", i), tbl[i].exp_count, tbl[i].exp_full_n, tbl[i].exp_empty_n);
    end
    chk("fill.err_ovf", 64'(ovf0), 64'h1);
    chk("drain.err_udf", 64'(udf0), 64'h1);

    // Async reset in the middle of a write burst.
    cycle(1'b1, 32'h10, 1'b0, 1'b0);
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    f0.if_write = 1'b1;
    f0.if_din   = 32'h12;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk_status("async_rst", 0, 1'b1, 1'b0);
    chk("async_rst.err", 64'({ovf0, udf0}), 64'h0);
    chk("async_rst.dout", 64'(f0.if_dout), 64'h0);
    f0.if_write = 1'b0;
    sb.delete();
    m_count = 0;
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 32'h3C, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_rst.dout", 64'(f0.if_dout), 64'h3C);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Write-to-visible latency with the output register.
    cycle(1'b1, 32'hA5, 1'b0, 1'b0);
    chk("lat_reg.1cyc_empty_n", 64'(f0.if_empty_n), 64'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("lat_reg.2cyc_empty_n", 64'(f0.if_empty_n), 64'h1);
    chk("lat_reg.dout", 64'(f0.if_dout), 64'hA5);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Same latency check on the combinational-output instance.
    chk("lat_comb.pre_empty_n", 64'(f1.if_empty_n), 64'h0);
    f1.if_write = 1'b1;
    f1.if_din   = 32'hA5;
    @(posedge clk);
    @(negedge clk);
    f1.if_write = 1'b0;
    chk("lat_comb.1cyc_empty_n", 64'(f1.if_empty_n), 64'h1);
    chk("lat_comb.dout", 64'(f1.if_dout), 64'hA5);
    chk("lat_comb.count", 64'(count1), 64'h1);
    f1.if_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    f1.if_read = 1'b0;
    chk("lat_comb.read_empty_n", 64'(f1.if_empty_n), 64'h0);
    chk("lat_comb.read_count", 64'(count1), 64'h0);

    // Flush with a concurrent write; sticky error must survive.
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush.pre_udf", 64'(udf0), 64'h1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk_status("flush.pre", 5, 1'b1, 1'b1);
    cycle(1'b1, 32'h77, 1'b0, 1'b1);
    chk_status("flush.post", 0, 1'b1, 1'b0);
    chk("flush.err_udf_kept", 64'(udf0), 64'h1);
    chk("flush.err_ovf", 64'(ovf0), 64'h0);
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk_status("flush.refill", 1, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Steady streaming at occupancy 8.
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk_status("stream.pre", 8, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
      chk("stream.count", 64'(count0), 64'h8);
    end
    drain("stream.drained");

    // Read+write at capacity: read taken, write refused.
    pulse_reset();
    for (int i = 0; i < CAP; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk_status("full", CAP, 1'b0, 1'b1);
    chk("full.err_ovf_clear", 64'(ovf0), 64'h0);
    cycle(1'b1, 32'hDEAD, 1'b1, 1'b0);
    chk_status("full_rw", CAP - 1, 1'b1, 1'b1);
    chk("full_rw.err_ovf", 64'(ovf0), 64'h1);
    drain("full_rw.drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
